// File: rtl/pim_job_arbiter.sv
// Round-robin arbiter sharing one PIM matmul engine between NUM_REQ requesters; one job in flight.
// Accept->eng_start 1 cycle, eng_done->rsp 1 cycle; optional WAIT watchdog via `PIM_ARB_TIMEOUT_EN.
module pim_job_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_W         = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_src1,
  input  logic [NUM_REQ*ADDR_W-1:0] req_src2,
  input  logic [NUM_REQ*ADDR_W-1:0] req_dst,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rsp_err,
  output logic                      eng_start,
  output logic [ADDR_W-1:0]         eng_src1_addr,
  output logic [ADDR_W-1:0]         eng_src2_addr,
  output logic [ADDR_W-1:0]         eng_dst_addr,
  input  logic                      eng_done,
  output logic                      busy,
  output logic                      spurious_done
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t             state;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   owner;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   next_ptr;
  logic               found;
  logic [NUM_REQ-1:0] owner_oh;
  logic               tmo_hit;

  logic [ADDR_W-1:0] src1_arr [NUM_REQ];
  logic [ADDR_W-1:0] src2_arr [NUM_REQ];
  logic [ADDR_W-1:0] dst_arr  [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign src1_arr[g] = req_src1[g*ADDR_W +: ADDR_W];
    assign src2_arr[g] = req_src2[g*ADDR_W +: ADDR_W];
    assign dst_arr[g]  = req_dst[g*ADDR_W +: ADDR_W];
  end

  // First valid requester at or after rr_ptr, wrapping.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) req_ready[winner] = 1'b1;
  end

  assign owner_oh = NUM_REQ'(1) << owner;
  assign next_ptr = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;

`ifdef PIM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;
  logic             err_q;

  assign tmo_hit = (tmo_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_err = err_q;

  // err_q is loaded on the last WAIT edge so it lines up with the RESP cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else if (state == WAIT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
      err_q   <= !eng_done && tmo_hit;
    end else begin
      tmo_cnt <= '0;
      if (state == RESP) err_q <= 1'b0;
    end
  end
`else
  logic unused_tmo;
  assign unused_tmo = (TIMEOUT_CYCLES == 0);
  assign tmo_hit    = 1'b0;
  assign rsp_err    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      owner         <= '0;
      busy          <= 1'b0;
      eng_start     <= 1'b0;
      rsp_valid     <= '0;
      eng_src1_addr <= '0;
      eng_src2_addr <= '0;
      eng_dst_addr  <= '0;
      spurious_done <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      if (eng_done && state != WAIT) spurious_done <= 1'b1;
      case (state)
        IDLE: begin
          if (found) begin
            eng_src1_addr <= src1_arr[winner];
            eng_src2_addr <= src2_arr[winner];
            eng_dst_addr  <= dst_arr[winner];
            owner         <= winner;
            busy          <= 1'b1;
            eng_start     <= 1'b1;
            state         <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (eng_done || tmo_hit) begin
            rsp_valid <= owner_oh;
            state     <= RESP;
          end
        end
        RESP: begin
          rsp_valid <= '0;
          busy      <= 1'b0;
          rr_ptr    <= next_ptr;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pim_job_arbiter.sv
// Directed bench for pim_job_arbiter: handshake, round-robin order, spurious done, async reset, timeout.
module tb_pim_job_arbiter;
  localparam int N  = 4;
  localparam int AW = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [N-1:0]      req_valid = '0;
  logic [N-1:0]      req_ready;
  logic [N*AW-1:0]   req_src1, req_src2, req_dst;
  logic [N-1:0]      rsp_valid;
  logic              rsp_err;
  logic              eng_start;
  logic [AW-1:0]     eng_src1_addr, eng_src2_addr, eng_dst_addr;
  logic              eng_done = 1'b0;
  logic              busy;
  logic              spurious_done;

  logic [AW-1:0] s1 [N];
  logic [AW-1:0] s2 [N];
  logic [AW-1:0] dd [N];

  int n_tests = 0;
  int n_fail  = 0;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_src1[g*AW +: AW] = s1[g];
    assign req_src2[g*AW +: AW] = s2[g];
    assign req_dst[g*AW +: AW]  = dd[g];
  end

  always #5 clk = ~clk;

  pim_job_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_src1(req_src1), .req_src2(req_src2), .req_dst(req_dst),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .eng_start(eng_start),
    .eng_src1_addr(eng_src1_addr), .eng_src2_addr(eng_src2_addr), .eng_dst_addr(eng_dst_addr),
    .eng_done(eng_done), .busy(busy), .spurious_done(spurious_done)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] c);
    s1[i[1:0]] = a;
    s2[i[1:0]] = b;
    dd[i[1:0]] = c;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    eng_done = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    for (int i = 0; i < N; i++) set_addr(i, '0, '0, '0);
    #2 rst = 1'b1;
    #1;
    n_tests++;
    if ({busy, eng_start, rsp_valid, rsp_err, spurious_done} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl got=%b exp=%b", {busy, eng_start, rsp_valid, rsp_err, spurious_done}, 8'b0);
    end
    n_tests++;
    if ({eng_src1_addr, eng_src2_addr, eng_dst_addr} !== 48'h0) begin
      n_fail++;
      $display("FAIL reset_addr got=%h exp=0", {eng_src1_addr, eng_src2_addr, eng_dst_addr});
    end
    tick;
    tick;
    rst = 1'b0;
  endtask

  task automatic test_single_job;
    set_addr(1, 16'h10, 16'h20, 16'h30);
    req_valid = 4'b0010;
    #1;
    n_tests++;
    if ({req_ready, busy} !== 5'b0010_0) begin
      n_fail++;
      $display("FAIL single_ready got=%b exp=%b", {req_ready, busy}, 5'b0010_0);
    end
    tick;
    n_tests++;
    if ({eng_start, busy, req_ready} !== 6'b11_0000) begin
      n_fail++;
      $display("FAIL single_start got=%b exp=%b", {eng_start, busy, req_ready}, 6'b11_0000);
    end
    n_tests++;
    if ({eng_src1_addr, eng_src2_addr, eng_dst_addr} !== {16'h10, 16'h20, 16'h30}) begin
      n_fail++;
      $display("FAIL single_addr got=%h exp=%h", {eng_src1_addr, eng_src2_addr, eng_dst_addr}, {16'h10, 16'h20, 16'h30});
    end
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      tick;
      n_tests++;
      if ({eng_start, busy, rsp_valid} !== 6'b01_0000) begin
        n_fail++;
        $display("FAIL single_wait%0d got=%b exp=%b", c, {eng_start, busy, rsp_valid}, 6'b01_0000);
      end
    end
    tick;
    eng_done = 1'b1;
    tick;
    eng_done = 1'b0;
    n_tests++;
    if ({rsp_valid, rsp_err, busy} !== 6'b0010_0_1) begin
      n_fail++;
      $display("FAIL single_rsp got=%b exp=%b", {rsp_valid, rsp_err, busy}, 6'b0010_0_1);
    end
    n_tests++;
    if (eng_dst_addr !== 16'h30) begin
      n_fail++;
      $display("FAIL single_addr_hold got=%h exp=%h", eng_dst_addr, 16'h30);
    end
    tick;
    n_tests++;
    if ({rsp_valid, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL single_after got=%b exp=%b", {rsp_valid, busy}, 5'b0);
    end
  endtask

  task automatic test_round_robin;
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset;
    for (int i = 0; i < N; i++) set_addr(i, 16'(16'h100 + i), 16'(16'h200 + i), 16'(16'h300 + i));
    req_valid = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      #1;
      n_tests++;
      if (req_ready !== (N'(1) << order[j])) begin
        n_fail++;
        $display("FAIL rr_grant%0d got=%b exp=%b", j, req_ready, N'(1) << order[j]);
      end
      tick;
      n_tests++;
      if ({eng_start, eng_src1_addr, eng_dst_addr} !== {1'b1, 16'(16'h100 + order[j]), 16'(16'h300 + order[j])}) begin
        n_fail++;
        $display("FAIL rr_start%0d got=%h exp=%h", j, {eng_start, eng_src1_addr, eng_dst_addr},
                 {1'b1, 16'(16'h100 + order[j]), 16'(16'h300 + order[j])});
      end
      tick;
      tick;
      n_tests++;
      if ({eng_start, rsp_valid} !== 5'b0) begin
        n_fail++;
        $display("FAIL rr_wait%0d got=%b exp=%b", j, {eng_start, rsp_valid}, 5'b0);
      end
      tick;
      eng_done = 1'b1;
      tick;
      eng_done = 1'b0;
      n_tests++;
      if ({rsp_valid, eng_start, req_ready} !== {N'(1) << order[j], 1'b0, 4'b0}) begin
        n_fail++;
        $display("FAIL rr_rsp%0d got=%b exp=%b", j, {rsp_valid, eng_start, req_ready}, {N'(1) << order[j], 1'b0, 4'b0});
      end
      tick;
    end
    req_valid = '0;
  endtask

  task automatic test_alternate;
    int order [5] = '{0, 2, 0, 2, 0};
    do_reset;
    req_valid = 4'b0101;
    for (int j = 0; j < 5; j++) begin
      #1;
      n_tests++;
      if (req_ready !== (N'(1) << order[j])) begin
        n_fail++;
        $display("FAIL alt_grant%0d got=%b exp=%b", j, req_ready, N'(1) << order[j]);
      end
      tick;
      tick;
      eng_done = 1'b1;
      tick;
      eng_done = 1'b0;
      n_tests++;
      if (rsp_valid !== (N'(1) << order[j])) begin
        n_fail++;
        $display("FAIL alt_rsp%0d got=%b exp=%b", j, rsp_valid, N'(1) << order[j]);
      end
      tick;
    end
    req_valid = '0;
  endtask

  task automatic test_spurious;
    n_tests++;
    if (spurious_done !== 1'b0) begin
      n_fail++;
      $display("FAIL spur_clear got=%b exp=0", spurious_done);
    end
    eng_done = 1'b1;
    tick;
    eng_done = 1'b0;
    n_tests++;
    if ({spurious_done, busy, eng_start} !== 3'b100) begin
      n_fail++;
      $display("FAIL spur_set got=%b exp=%b", {spurious_done, busy, eng_start}, 3'b100);
    end
    set_addr(1, 16'h0111, 16'h0222, 16'h0333);
    req_valid = 4'b0010;
    #1;
    n_tests++;
    if (req_ready !== 4'b0010) begin
      n_fail++;
      $display("FAIL spur_ready got=%b exp=%b", req_ready, 4'b0010);
    end
    tick;
    req_valid = '0;
    tick;
    eng_done = 1'b1;
    tick;
    eng_done = 1'b0;
    n_tests++;
    if ({rsp_valid, rsp_err, spurious_done} !== 6'b0010_0_1) begin
      n_fail++;
      $display("FAIL spur_job got=%b exp=%b", {rsp_valid, rsp_err, spurious_done}, 6'b0010_0_1);
    end
    tick;
    n_tests++;
    if ({spurious_done, busy} !== 2'b10) begin
      n_fail++;
      $display("FAIL spur_sticky got=%b exp=%b", {spurious_done, busy}, 2'b10);
    end
  endtask

  task automatic test_async_reset;
    set_addr(0, 16'hAAAA, 16'hBBBB, 16'hCCCC);
    req_valid = 4'b0001;
    tick;
    req_valid = '0;
    tick;
    tick;
    #3 rst = 1'b1;
    #1;
    n_tests++;
    if ({busy, eng_start, rsp_valid, spurious_done} !== 7'b0) begin
      n_fail++;
      $display("FAIL arst_ctrl got=%b exp=%b", {busy, eng_start, rsp_valid, spurious_done}, 7'b0);
    end
    n_tests++;
    if ({eng_src1_addr, eng_dst_addr} !== 32'h0) begin
      n_fail++;
      $display("FAIL arst_addr got=%h exp=0", {eng_src1_addr, eng_dst_addr});
    end
    tick;
    tick;
    rst = 1'b0;
    tick;
    n_tests++;
    if ({rsp_valid, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL arst_norsp got=%b exp=%b", {rsp_valid, busy}, 5'b0);
    end
    set_addr(3, 16'h3001, 16'h3002, 16'h3003);
    req_valid = 4'b1000;
    #1;
    n_tests++;
    if (req_ready !== 4'b1000) begin
      n_fail++;
      $display("FAIL arst_ready got=%b exp=%b", req_ready, 4'b1000);
    end
    tick;
    req_valid = '0;
    n_tests++;
    if ({eng_start, eng_src1_addr, eng_src2_addr, eng_dst_addr} !== {1'b1, 16'h3001, 16'h3002, 16'h3003}) begin
      n_fail++;
      $display("FAIL arst_start got=%h exp=%h", {eng_start, eng_src1_addr, eng_src2_addr, eng_dst_addr},
               {1'b1, 16'h3001, 16'h3002, 16'h3003});
    end
    tick;
    eng_done = 1'b1;
    tick;
    eng_done = 1'b0;
    n_tests++;
    if ({rsp_valid, rsp_err} !== 5'b1000_0) begin
      n_fail++;
      $display("FAIL arst_rsp got=%b exp=%b", {rsp_valid, rsp_err}, 5'b1000_0);
    end
    tick;
  endtask

`ifdef PIM_ARB_TIMEOUT_EN
  task automatic test_timeout;
    do_reset;
    set_addr(2, 16'h0020, 16'h0021, 16'h0022);
    req_valid = 4'b0100;
    tick;
    req_valid = '0;
    n_tests++;
    if (eng_start !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_start got=%b exp=1", eng_start);
    end
    for (int c = 0; c < 8; c++) begin
      tick;
      n_tests++;
      if ({rsp_valid, busy} !== 5'b0000_1) begin
        n_fail++;
        $display("FAIL tmo_wait%0d got=%b exp=%b", c, {rsp_valid, busy}, 5'b0000_1);
      end
    end
    tick;
    n_tests++;
    if ({rsp_valid, rsp_err} !== 5'b0100_1) begin
      n_fail++;
      $display("FAIL tmo_rsp got=%b exp=%b", {rsp_valid, rsp_err}, 5'b0100_1);
    end
    tick;
    n_tests++;
    if ({rsp_valid, rsp_err, spurious_done} !== 6'b0) begin
      n_fail++;
      $display("FAIL tmo_after got=%b exp=%b", {rsp_valid, rsp_err, spurious_done}, 6'b0);
    end
    eng_done = 1'b1;
    tick;
    eng_done = 1'b0;
    n_tests++;
    if (spurious_done !== 1'b1) begin
      n_fail++;
      $display("FAIL tmo_late_done got=%b exp=1", spurious_done);
    end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog expired tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_single_job;
    test_round_robin;
    test_alternate;
    test_spurious;
    test_async_reset;
`ifdef PIM_ARB_TIMEOUT_EN
    test_timeout;
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
